// File: rtl/wb_pkg.sv
// wb_pkg: shared entry layout and mask constants for the write buffer
package wb_pkg;
  localparam int MASK_W = 4;
  localparam int ENTRY_W = 32;
  localparam logic [MASK_W-1:0] FULL_MASK = '1;
  typedef struct packed {
    logic [ENTRY_W-1:0] addr;
    logic [ENTRY_W-1:0] data;
    logic [MASK_W-1:0]  mask;
  } entry_t;
endpackage

// File: rtl/wb_match.sv
// wb_match: word-address compare of a load against all valid entries, reporting the youngest match
module wb_match
  import wb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  entry_t            mem [DEPTH],
  input  logic [DEPTH-1:0]  valid,
  input  logic [PW-1:0]     rp,
  input  logic [WIDTH-1:0]  ld_addr,
  output logic              hit,
  output logic              yfull,
  output logic [WIDTH-1:0]  ydata
);
  logic [PW-1:0] idx;
  // walk oldest to youngest from the read pointer so the last match seen is the youngest
  always_comb begin
    hit = 1'b0;
    yfull = 1'b0;
    ydata = '0;
    idx = rp;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rp + PW'(k);
      if (valid[idx] && ((WIDTH'(mem[idx].addr) ^ ld_addr) >> 2) == '0) begin
        hit = 1'b1;
        yfull = mem[idx].mask == FULL_MASK;
        ydata = WIDTH'(mem[idx].data);
      end
    end
  end
endmodule

// File: rtl/write_buffer.sv
// write_buffer: store FIFO between memory stage and RAM; WRITE_BUFFER_FORWARD_EN enables full-word load forwarding
module write_buffer
  import wb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  input  logic [WIDTH-1:0]         st_addr,
  input  logic [WIDTH-1:0]         st_data,
  input  logic [MASK_W-1:0]        st_mask,
  input  logic                     ld_valid,
  input  logic [WIDTH-1:0]         ld_addr,
  output logic                     stall,
  output logic                     fwd_hit,
  output logic [WIDTH-1:0]         fwd_data,
  output logic                     ram_wen,
  output logic [WIDTH-1:0]         ram_addr,
  output logic [WIDTH-1:0]         ram_wd,
  output logic [MASK_W-1:0]        ram_mask,
  input  logic                     ram_ready,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0] rp, wp;
  logic full, pop, push, hit, yfull, fwd_ok;
  logic [WIDTH-1:0] ydata;
  wb_match #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_match (
    .mem(mem), .valid(valid), .rp(rp), .ld_addr(ld_addr),
    .hit(hit), .yfull(yfull), .ydata(ydata)
  );
  assign empty = count == '0;
  assign full = count == (PW+1)'(DEPTH);
  assign ram_wen = !empty;
  assign ram_addr = WIDTH'(mem[rp].addr);
  assign ram_wd = WIDTH'(mem[rp].data);
  assign ram_mask = mem[rp].mask;
`ifdef WRITE_BUFFER_FORWARD_EN
  assign fwd_ok = hit && yfull;
  assign fwd_hit = ld_valid && !st_valid && fwd_ok;
  assign fwd_data = fwd_hit ? ydata : '0;
`else
  logic fwd_unused;
  assign fwd_unused = ^{yfull, ydata};
  assign fwd_ok = 1'b0;
  assign fwd_hit = 1'b0;
  assign fwd_data = '0;
`endif
  assign stall = st_valid ? full && !ram_ready : ld_valid && hit && !fwd_ok;
  assign pop = ram_wen && ram_ready;
  assign push = st_valid && !stall;
  // pointers, occupancy and valid bits; a simultaneous pop and push on a full buffer share a slot, so the push's set wins
  always_ff @(posedge clk) begin
    if (rst) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (pop) begin
        rp <= rp + PW'(1);
        valid[rp] <= 1'b0;
      end
      if (push) begin
        wp <= wp + PW'(1);
        valid[wp] <= 1'b1;
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  // entry storage needs no reset since valid bits gate every use
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= '{addr: ENTRY_W'(st_addr), data: ENTRY_W'(st_data), mask: st_mask};
  end
endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data/address width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning entry count (power of two, >=2).
REQ-003 SHALL have ports clk in 1, the single clock, and rst in 1, a synchronous active-high reset sampled on the rising edge of clk.
REQ-004 SHALL have st_valid in 1: memory stage presents a store this cycle.
REQ-005 SHALL have st_addr in WIDTH, st_data in WIDTH (already lane-aligned) and st_mask in 4 (byte enables).
REQ-006 SHALL have ld_valid in 1 and ld_addr in WIDTH: memory stage presents a load this cycle.
REQ-007 SHALL have stall out 1: the memory-stage instruction is not complete and upstream holds.
REQ-008 SHALL have fwd_hit out 1 and fwd_data out WIDTH: load served from buffer.
REQ-009 SHALL have ram_wen out 1, ram_addr out WIDTH, ram_wd out WIDTH and ram_mask out 4: the RAM write port.
REQ-010 SHALL have ram_ready in 1: RAM accepts the presented write this cycle.
REQ-011 SHALL have empty out 1 and count out $clog2(DEPTH)+1.

Function
REQ-012 SHALL be a FIFO of {addr, data, mask} entries placed between the memory stage and RAM; the cache is still written directly by the memory stage.
REQ-013 SHALL drive ram_wen = !empty, with ram_addr/ram_wd/ram_mask taken combinationally from the head entry.
REQ-014 SHALL pop the head on the rising edge when ram_wen && ram_ready.
REQ-015 SHALL enqueue on the rising edge when st_valid && !stall; a store presented in an empty buffer reaches ram_wen one cycle later.
REQ-016 SHALL drive stall = st_valid && full && !ram_ready for stores; when full and popping in the same cycle, the push is accepted and count is unchanged.
REQ-017 SHALL compare loads on word address (addr[WIDTH-1:2]) against every valid entry; any match is a hazard.
REQ-018 SHALL assert stall on a load hazard, without forwarding, until no matching entry remains.
REQ-019 SHALL treat st_valid && ld_valid together as illegal; st_valid takes precedence and the load is ignored.
REQ-020 SHALL wrap the read/write pointers modulo DEPTH; count SHALL range 0..DEPTH, with full = (count==DEPTH).
REQ-021 SHALL hold ram_* values stable while ram_wen && !ram_ready.
REQ-022 SHALL make a pop of the matching entry remove the hazard in the following cycle; the stall is combinational on current contents.

Reset
REQ-023 SHALL, on rst, clear the pointers, count and all entry valid bits; pending stores are discarded, including one mid-drain.
REQ-024 SHALL drive outputs after reset to: stall=0, ram_wen=0, fwd_hit=0, fwd_data=0, empty=1, count=0.
REQ-025 SHALL give rst priority over a simultaneous push or pop.

Configuration
REQ-026 SHALL compile forwarding in with macro WRITE_BUFFER_FORWARD_EN.
REQ-027 SHALL, with WRITE_BUFFER_FORWARD_EN defined, forward when the youngest matching entry has mask 4'b1111: fwd_hit=1, fwd_data=that entry's data, and no stall; a partial-mask youngest match still stalls.
REQ-028 SHALL, without WRITE_BUFFER_FORWARD_EN, tie fwd_hit=0 and fwd_data=0, so every hazard stalls.

Structure
REQ-029 SHALL place the entry struct (addr, data, mask), the MASK_W=4 constant and the full-mask constant in shared package wb_pkg.
REQ-030 SHALL implement the address-compare and youngest-match priority in one sub-module, wb_match.

Verification
REQ-031 Store 0x100/0xDEADBEEF/1111 into an empty buffer with ram_ready=1 -> next cycle ram_wen=1, ram_addr=0x100; the following cycle empty=1.
REQ-032 Hold ram_ready=0 and issue 5 stores (DEPTH=4) -> count=4; the 5th store sees stall=1; one cycle of ram_ready=1 -> 5th accepted, count stays 4.
REQ-033 Buffer holds 0x200 mask 0011 and a load of 0x202 arrives -> stall=1 until 0x200 drains, then stall=0 (both builds).
REQ-034 With forwarding, buffer holds 0x300=0x11111111 then 0x300=0x22222222 (both 1111) and a load of 0x300 arrives -> fwd_hit=1, fwd_data=0x22222222, stall=0; without the macro -> stall=1.
REQ-035 Assert rst with 3 entries pending and ram_ready=0 -> next cycle count=0, empty=1, ram_wen=0, stall=0.
REQ-036 With count=3, head=2, ram_ready=1, issue back-to-back stores for 8 cycles -> pointer wrap, FIFO order preserved on ram_addr.
